sync_fifo_16x8: RTL and testbench

// - Single-clock FIFO, 16 entries x 8 bits, with active-low read/write strobes.
// - Buffers byte streams between producer and consumer logic in the same clock domain.
// - Provides full/empty status so neighbours never overrun or underrun the buffer.
//

---
 rtl/sync_fifo_pkg.sv | 8 +
 rtl/fifo_mem_16x8.sv | 24 ++
 rtl/sync_fifo_16x8.sv | 75 +++++++
 tb/tb_sync_fifo_16x8.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing for the 16x8 single-clock FIFO.
// Pointers wrap naturally at ADDR_W bits; count needs one extra bit.
package sync_fifo_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
endpackage

// File: rtl/fifo_mem_16x8.sv
// 16x8 storage array: one synchronous write port, one combinational read port.
// Contents are never reset; the empty check keeps unwritten words from being read.
module fifo_mem_16x8
  import sync_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_16x8.sv
// Single-clock 16x8 FIFO with active-low strobes and registered read data.
// Pointers, occupancy count and flags live here; storage is in fifo_mem_16x8.
module sync_fifo_16x8
  import sync_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_n,
  input  logic              write_n,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_en;
  logic              wr_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A read frees a slot this edge, so a write while full may proceed
  assign rd_en = !read_n && !empty;
  assign wr_en = !write_n && (!full || rd_en);

  fifo_mem_16x8 u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_rdata;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_sync_fifo_16x8.sv
// Directed bench for sync_fifo_16x8: fill, drain, wrap, simultaneous access,
// and asynchronous reset, with hand-computed expectations.
module tb_sync_fifo_16x8;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       read_n;
  logic       write_n;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int vectors;
  int miscompares;

  sync_fifo_16x8 dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .read_n   (read_n),
    .write_n  (write_n),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic e, input logic f);
    chk({tag, ".empty"}, {7'd0, empty}, {7'd0, e});
    chk({tag, ".full"}, {7'd0, full}, {7'd0, f});
  endtask

  // One clock with the given strobes; returns #1 after the edge, idle
  task automatic cyc(input logic wn, input logic rn, input logic [7:0] d);
    write_n = wn;
    read_n  = rn;
    data_in = d;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    read_n  = 1'b1;
    data_in = 8'h00;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic rd();
    cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic both(input logic [7:0] d);
    cyc(1'b0, 1'b0, d);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    read_n  = 1'b1;
    write_n = 1'b1;
    data_in = 8'h00;

    // Asynchronous reset mid-cycle, checked before the next edge
    @(posedge clk);
    #2;
    rst = 1'b0;
    #2;
    flags("reset", 1'b1, 1'b0);
    chk("reset.dout", data_out, 8'h00);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      flags($sformatf("fill%0d", i), 1'b0, i == 16);
    end
    wr(8'hFF);
    flags("fill17", 1'b0, 1'b1);

    // Drain in order; 17th read leaves data_out alone
    for (int i = 1; i <= 16; i++) begin
      rd();
      chk($sformatf("drain%0d", i), data_out, 8'(i));
      flags($sformatf("drain%0d", i), i == 16, 1'b0);
    end
    rd();
    chk("drain17", data_out, 8'h10);
    flags("drain17", 1'b1, 1'b0);

    // Wrap: 10 in/out, then 12 in/out crossing 15->0
    for (int i = 0; i < 10; i++) wr(8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      rd();
      chk($sformatf("wrapA%0d", i), data_out, 8'h20 + 8'(i));
    end
    flags("wrapA", 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      wr(8'h40 + 8'(i));
      flags($sformatf("wrapBw%0d", i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      rd();
      chk($sformatf("wrapB%0d", i), data_out, 8'h40 + 8'(i));
      flags($sformatf("wrapBr%0d", i), i == 11, 1'b0);
    end

    // Simultaneous with 5 stored
    for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      both(8'h60 + 8'(i));
      chk($sformatf("simul%0d", i), data_out, 8'h50 + 8'(i));
      flags($sformatf("simul%0d", i), 1'b0, 1'b0);
    end
    rd();
    chk("simul.r0", data_out, 8'h54);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk($sformatf("simul.r%0d", i + 1), data_out, 8'h60 + 8'(i));
    end
    flags("simul.end", 1'b1, 1'b0);

    // Full plus both: read oldest, stay full
    for (int i = 0; i < 16; i++) wr(8'h70 + 8'(i));
    flags("fullboth.pre", 1'b0, 1'b1);
    both(8'hAA);
    chk("fullboth", data_out, 8'h70);
    flags("fullboth", 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      rd();
      chk($sformatf("fullboth.r%0d", i), data_out, 8'h70 + 8'(i));
    end
    rd();
    chk("fullboth.last", data_out, 8'hAA);
    flags("fullboth.end", 1'b1, 1'b0);

    // Empty plus both: write only, data_out unchanged
    both(8'hBB);
    chk("emptyboth", data_out, 8'hAA);
    flags("emptyboth", 1'b0, 1'b0);
    rd();
    chk("emptyboth.r", data_out, 8'hBB);
    flags("emptyboth.r", 1'b1, 1'b0);

    // Reset with 7 stored discards everything
    for (int i = 0; i < 7; i++) wr(8'h90 + 8'(i));
    flags("midrst.pre", 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    flags("midrst", 1'b1, 1'b0);
    chk("midrst.dout", data_out, 8'h00);
    #3;
    rst = 1'b1;
    wr(8'hC3);
    flags("midrst.w", 1'b0, 1'b0);
    rd();
    chk("midrst.r", data_out, 8'hC3);
    flags("midrst.r", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
